bcd4_to_bin14: RTL and testbench

Sequential converter from four BCD digits (0000-9999) to a 14-bit unsigned binary value, using the reverse double-dabble (shift-right, subtract-3) algorithm, one bit per clock. It is the inverse of the score/line-count binary-to-BCD display path. It sits between BCD-entry sources (keypad/switch digit entry, stored high-score digits) and binary game logic. Conversion uses a start/done handshake. Invalid digits are flagged rather than converted.

---
 rtl/bcd4_to_bin14.sv | 86 ++++++++
 tb/tb_bcd4_to_bin14.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/bcd4_to_bin14.sv
// Sequential four-digit BCD to 14-bit binary converter using reverse double-dabble
// (shift right, then subtract 3 from any nibble >= 8), one bit per clock.
module bcd4_to_bin14 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [3:0]  bcd3,
  input  logic [3:0]  bcd2,
  input  logic [3:0]  bcd1,
  input  logic [3:0]  bcd0,
  output logic        busy,
  output logic        done,
  output logic [13:0] bin,
  output logic        err
);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [29:0] sreg;
  logic [29:0] sreg_nxt;
  logic [3:0]  cnt;
  logic        bad_digit;

  // One reverse double-dabble step: shift right, then correct each BCD nibble independently.
  function automatic logic [29:0] shift_fix(input logic [29:0] r);
    logic [29:0] s;
    s = r >> 1;
    for (int i = 0; i < 4; i++) begin
      if (s[14+4*i +: 4] >= 4'd8)
        s[14+4*i +: 4] = s[14+4*i +: 4] - 4'd3;
    end
    return s;
  endfunction

  assign bad_digit = (bcd3 > 4'd9) || (bcd2 > 4'd9) || (bcd1 > 4'd9) || (bcd0 > 4'd9);
  assign sreg_nxt  = shift_fix(sreg);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = bad_digit ? S_DONE : S_SHIFT;
      S_SHIFT: if (cnt == 4'd13) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Datapath: result is registered on the last shift so it is valid while in S_DONE.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sreg <= '0;
      cnt  <= '0;
      bin  <= '0;
      err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            sreg <= {bcd3, bcd2, bcd1, bcd0, 14'b0};
            cnt  <= '0;
            bin  <= '0;
            err  <= bad_digit;
          end
        end
        S_SHIFT: begin
          sreg <= sreg_nxt;
          cnt  <= cnt + 4'd1;
          if (cnt == 4'd13) bin <= sreg_nxt[13:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd4_to_bin14.sv
// Directed bench for bcd4_to_bin14: handshake timing, conversion values, invalid digits,
// ignored starts, back-to-back requests, mid-conversion reset and a strided value sweep.
module tb_bcd4_to_bin14;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  bcd3, bcd2, bcd1, bcd0;
  logic        busy, done, err;
  logic [13:0] bin;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  bcd4_to_bin14 dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .bcd3(bcd3), .bcd2(bcd2), .bcd1(bcd1), .bcd0(bcd0),
    .busy(busy), .done(done), .bin(bin), .err(err)
  );

  // Called at #1 after an edge with the DUT idle; returns at #1 into the cycle after DONE.
  // lat is the cycle index (k+lat) at which done was seen.
  task automatic run_conv(input logic [3:0] a3, a2, a1, a0,
                          output int lat, output logic [13:0] b, output logic e,
                          output bit hs_ok);
    bcd3 = a3; bcd2 = a2; bcd1 = a1; bcd0 = a0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bcd3 = ~a3; bcd2 = ~a2; bcd1 = ~a1; bcd0 = ~a0;
    lat = 1; hs_ok = 1'b1;
    while (done !== 1'b1 && lat < 40) begin
      if (busy !== 1'b1) hs_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b1) hs_ok = 1'b0;
    b = bin; e = err;
    @(posedge clk); #1;
    if (done !== 1'b0 || busy !== 1'b0) hs_ok = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0;
    bcd3 = 4'd0; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (bin !== 14'h0) begin fails++; $display("FAIL reset_bin: got %h want 0000", bin); end
    checks++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %b want 0", err); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    int lat; logic [13:0] b; logic e; bit ok;
    run_conv(4'd1, 4'd2, 4'd3, 4'd4, lat, b, e, ok);
    checks++; if (lat != 15) begin fails++; $display("FAIL basic_latency: got %0d want 15", lat); end
    checks++; if (b !== 14'h04D2) begin fails++; $display("FAIL basic_bin: got %h want 04d2", b); end
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL basic_err: got %b want 0", e); end
    checks++; if (!ok) begin fails++; $display("FAIL basic_handshake: busy/done shape wrong, got 0 want 1"); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bin !== 14'h04D2) begin fails++; $display("FAIL basic_hold: got %h want 04d2", bin); end
  endtask

  task automatic test_values();
    logic [3:0]  dig [3][4] = '{'{4'd9, 4'd9, 4'd9, 4'd9}, '{4'd0, 4'd0, 4'd0, 4'd0},
                                '{4'd0, 4'd0, 4'd0, 4'd1}};
    logic [13:0] exp [3] = '{14'h270F, 14'h0000, 14'h0001};
    int lat; logic [13:0] b; logic e; bit ok;
    for (int i = 0; i < 3; i++) begin
      run_conv(dig[i][0], dig[i][1], dig[i][2], dig[i][3], lat, b, e, ok);
      checks++; if (b !== exp[i]) begin fails++; $display("FAIL values_bin[%0d]: got %h want %h", i, b, exp[i]); end
      checks++; if (lat != 15) begin fails++; $display("FAIL values_latency[%0d]: got %0d want 15", i, lat); end
      checks++; if (e !== 1'b0 || !ok) begin fails++; $display("FAIL values_err_hs[%0d]: got err=%b hs=%0d want err=0 hs=1", i, e, ok); end
    end
  endtask

  task automatic test_invalid();
    int lat; logic [13:0] b; logic e; bit ok;
    run_conv(4'd3, 4'hA, 4'd0, 4'd0, lat, b, e, ok);
    checks++; if (lat != 1) begin fails++; $display("FAIL invalid_latency: got %0d want 1", lat); end
    checks++; if (e !== 1'b1) begin fails++; $display("FAIL invalid_err: got %b want 1", e); end
    checks++; if (b !== 14'h0) begin fails++; $display("FAIL invalid_bin: got %h want 0000", b); end
    checks++; if (!ok) begin fails++; $display("FAIL invalid_handshake: got 0 want 1"); end
    checks++; if (err !== 1'b1) begin fails++; $display("FAIL invalid_err_hold: got %b want 1", err); end
    run_conv(4'd0, 4'd0, 4'd4, 4'd2, lat, b, e, ok);
    checks++; if (e !== 1'b0) begin fails++; $display("FAIL invalid_recover_err: got %b want 0", e); end
    checks++; if (b !== 14'h002A) begin fails++; $display("FAIL invalid_recover_bin: got %h want 002a", b); end
    checks++; if (lat != 15) begin fails++; $display("FAIL invalid_recover_latency: got %0d want 15", lat); end
  endtask

  task automatic test_ignore_start();
    int t = 0; int done_cnt = 0; int done_at = 0;
    bcd3 = 4'd5; bcd2 = 4'd0; bcd1 = 4'd0; bcd0 = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (t = 1; t <= 40; t++) begin
      if (done === 1'b1) begin done_cnt++; done_at = t; end
      if (t == 15) begin
        checks++; if (bin !== 14'h1388) begin fails++; $display("FAIL ignore_bin: got %h want 1388", bin); end
      end
      if (t == 5) begin
        bcd3 = 4'd1; bcd2 = 4'd1; bcd1 = 4'd1; bcd0 = 4'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    checks++; if (done_cnt != 1) begin fails++; $display("FAIL ignore_done_count: got %0d want 1", done_cnt); end
    checks++; if (done_at != 15) begin fails++; $display("FAIL ignore_done_cycle: got %0d want 15", done_at); end
    checks++; if (bin !== 14'h1388) begin fails++; $display("FAIL ignore_bin_hold: got %h want 1388", bin); end
  endtask

  task automatic test_back_to_back();
    int d_first = -1; int d_second = -1; logic prev_done = 1'b0; bit consec = 1'b0;
    int w = 0;
    bcd3 = 4'd0; bcd2 = 4'd1; bcd1 = 4'd0; bcd0 = 4'd0; start = 1'b1;
    @(posedge clk); #1;
    for (int t = 1; t <= 40; t++) begin
      if (done === 1'b1) begin
        if (prev_done) consec = 1'b1;
        if (d_first < 0) d_first = t; else if (d_second < 0) d_second = t;
      end
      prev_done = done;
      @(posedge clk); #1;
    end
    start = 1'b0;
    while (busy !== 1'b0 && w < 40) begin @(posedge clk); #1; w++; end
    checks++; if (d_first != 15) begin fails++; $display("FAIL b2b_first: got %0d want 15", d_first); end
    checks++; if (d_second - d_first != 16) begin fails++; $display("FAIL b2b_spacing: got %0d want 16", d_second - d_first); end
    checks++; if (consec) begin fails++; $display("FAIL b2b_consecutive_done: got 1 want 0"); end
    checks++; if (bin !== 14'h0064 || busy !== 1'b0) begin fails++; $display("FAIL b2b_final: got bin=%h busy=%b want 0064/0", bin, busy); end
  endtask

  task automatic test_reset_mid();
    int done_cnt = 0; int lat; logic [13:0] b; logic e; bit ok;
    run_conv(4'd0, 4'd0, 4'd0, 4'd7, lat, b, e, ok);
    bcd3 = 4'd8; bcd2 = 4'd1; bcd1 = 4'd9; bcd0 = 4'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int t = 1; t < 7; t++) begin @(posedge clk); #1; end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin fails++; $display("FAIL rstmid_ctrl: got busy=%b done=%b want 0/0", busy, done); end
    checks++; if (bin !== 14'h0 || err !== 1'b0) begin fails++; $display("FAIL rstmid_data: got bin=%h err=%b want 0000/0", bin, err); end
    for (int t = 0; t < 20; t++) begin
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (done_cnt != 0) begin fails++; $display("FAIL rstmid_no_done: got %0d active cycles want 0", done_cnt); end
    // Reset coinciding with start drops the request.
    reset_n = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    reset_n = 1'b1; start = 1'b0;
    done_cnt = 0;
    for (int t = 0; t < 20; t++) begin
      if (done === 1'b1 || busy === 1'b1) done_cnt++;
      @(posedge clk); #1;
    end
    checks++; if (done_cnt != 0) begin fails++; $display("FAIL rst_with_start: got %0d active cycles want 0", done_cnt); end
    run_conv(4'd8, 4'd1, 4'd9, 4'd2, lat, b, e, ok);
    checks++; if (b !== 14'h2000 || e !== 1'b0) begin fails++; $display("FAIL rstmid_after: got bin=%h err=%b want 2000/0", b, e); end
    checks++; if (lat != 15) begin fails++; $display("FAIL rstmid_after_latency: got %0d want 15", lat); end
  endtask

  task automatic test_sweep();
    int lat; logic [13:0] b; logic e; bit ok;
    logic [13:0] exp;
    for (int v = 0; v < 10000; v += 7) begin
      exp = 14'(v);
      run_conv(4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10), lat, b, e, ok);
      checks++;
      if (b !== exp || e !== 1'b0) begin
        fails++; $display("FAIL sweep_bin[%0d]: got bin=%h err=%b want %h/0", v, b, e, exp);
      end
      checks++;
      if (lat != 15 || !ok) begin
        fails++; $display("FAIL sweep_latency[%0d]: got %0d hs=%0d want 15 hs=1", v, lat, ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_invalid();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
